// File: rtl/id_hazard_control_if.sv
// rtl/id_hazard_control_if.sv - ID-stage hazard/decode signal bundle between pipeline and control unit
interface id_hazard_control_if;
    logic [5:0] opcode_In;
    logic [4:0] rs_In;
    logic [4:0] rt_In;
    logic       idex_MemRead_In;
    logic [4:0] idex_rt_In;
    logic       branch_taken_In;

    logic [1:0] ALUOp_Out;
    logic       RegDst_Out;
    logic       Branch_Out;
    logic       MemRead_Out;
    logic       MemtoReg_Out;
    logic       MemWrite_Out;
    logic       ALUSrc_Out;
    logic       RegWrite_Out;
    logic [5:0] opcode_Out;

    logic       PCWrite_Out;
    logic       IFID_Write_Out;
    logic       IFID_Flush_Out;
    logic       IDEX_Flush_Out;
    logic       EXMEM_Flush_Out;

    logic       illegal_Out;
    logic [7:0] stall_count_Out;
    logic [7:0] flush_count_Out;

    modport master (
        output opcode_In, rs_In, rt_In, idex_MemRead_In, idex_rt_In, branch_taken_In,
        input  ALUOp_Out, RegDst_Out, Branch_Out, MemRead_Out, MemtoReg_Out, MemWrite_Out,
               ALUSrc_Out, RegWrite_Out, opcode_Out,
               PCWrite_Out, IFID_Write_Out, IFID_Flush_Out, IDEX_Flush_Out, EXMEM_Flush_Out,
               illegal_Out, stall_count_Out, flush_count_Out
    );

    modport slave (
        input  opcode_In, rs_In, rt_In, idex_MemRead_In, idex_rt_In, branch_taken_In,
        output ALUOp_Out, RegDst_Out, Branch_Out, MemRead_Out, MemtoReg_Out, MemWrite_Out,
               ALUSrc_Out, RegWrite_Out, opcode_Out,
               PCWrite_Out, IFID_Write_Out, IFID_Flush_Out, IDEX_Flush_Out, EXMEM_Flush_Out,
               illegal_Out, stall_count_Out, flush_count_Out
    );
endinterface

// File: rtl/id_hazard_control.sv
// rtl/id_hazard_control.sv - ID-stage decode, load-use stall and branch flush steering
module id_hazard_control (
    input  logic                clk,
    input  logic                rst,
    id_hazard_control_if.slave  bus
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;

    state_t     state_q, state_d;
    logic [8:0] ctrl;
    logic       legal;
    logic       uses_rt;
    logic       hazard;
    logic       bubble;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush;
    logic       stall_evt;
    logic       illegal_q, illegal_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] flush_cnt_q, flush_cnt_d;

    // ctrl = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
    always_comb begin
        ctrl    = 9'b0;
        legal   = 1'b1;
        uses_rt = 1'b0;
        case (bus.opcode_In)
            6'b000000: begin ctrl = 9'b1_0_0_1_0_0_0_10; uses_rt = 1'b1; end
            6'b100011: ctrl = 9'b0_1_1_1_1_0_0_00;
            6'b101011: begin ctrl = 9'b0_1_0_0_0_1_0_00; uses_rt = 1'b1; end
            6'b000100: begin ctrl = 9'b0_0_0_0_0_0_1_01; uses_rt = 1'b1; end
            6'b001000: ctrl = 9'b0_1_0_1_0_0_0_00;
            default:   legal = 1'b0;
        endcase
    end

    assign hazard = bus.idex_MemRead_In && (bus.idex_rt_In != 5'd0) &&
                    ((bus.idex_rt_In == bus.rs_In) || (uses_rt && (bus.idex_rt_In == bus.rt_In)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = RUN;
        case (state_q)
            RUN:     state_d = bus.branch_taken_In ? FLUSH : (hazard ? STALL : RUN);
            STALL:   state_d = bus.branch_taken_In ? FLUSH : RUN;
            FLUSH:   state_d = bus.branch_taken_In ? FLUSH : RUN;
            default: state_d = RUN;
        endcase
    end

    // FLUSH without a new branch only kills the single wrong-path fetch behind the redirect.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        bubble      = 1'b0;
        if (bus.branch_taken_In) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            bubble      = 1'b1;
        end else if (state_q == FLUSH) begin
            ifid_flush  = 1'b1;
            bubble      = 1'b1;
        end else if (state_q == RUN && hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            bubble      = 1'b1;
        end
    end

    assign stall_evt   = (state_q == RUN) && !bus.branch_taken_In && hazard;
    assign illegal_d   = illegal_q | ~legal;
    assign stall_cnt_d = (stall_evt && stall_cnt_q != 8'hFF) ? stall_cnt_q + 8'd1 : stall_cnt_q;
    assign flush_cnt_d = (bus.branch_taken_In && flush_cnt_q != 8'hFF) ? flush_cnt_q + 8'd1 : flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q   <= 1'b0;
            stall_cnt_q <= 8'd0;
            flush_cnt_q <= 8'd0;
        end else begin
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign {bus.RegDst_Out, bus.ALUSrc_Out, bus.MemtoReg_Out, bus.RegWrite_Out,
            bus.MemRead_Out, bus.MemWrite_Out, bus.Branch_Out, bus.ALUOp_Out} = bubble ? 9'b0 : ctrl;
    assign bus.opcode_Out      = bubble ? 6'b0 : bus.opcode_In;
    assign bus.PCWrite_Out     = pc_write;
    assign bus.IFID_Write_Out  = ifid_write;
    assign bus.IFID_Flush_Out  = ifid_flush;
    assign bus.IDEX_Flush_Out  = idex_flush;
    assign bus.EXMEM_Flush_Out = exmem_flush;
    assign bus.illegal_Out     = illegal_q;
    assign bus.stall_count_Out = stall_cnt_q;
    assign bus.flush_count_Out = flush_cnt_q;
endmodule

// File: tb/tb_id_hazard_control.sv
// tb/tb_id_hazard_control.sv - directed scoreboard bench for id_hazard_control
module tb_id_hazard_control;
    logic clk;
    logic rst;
    id_hazard_control_if ifc();

    id_hazard_control dut (.clk(clk), .rst(rst), .bus(ifc.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [8:0] C_R    = 9'b1_0_0_1_0_0_0_10;
    localparam logic [8:0] C_LW   = 9'b0_1_1_1_1_0_0_00;
    localparam logic [8:0] C_SW   = 9'b0_1_0_0_0_1_0_00;
    localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
    localparam logic [8:0] C_ADDI = 9'b0_1_0_1_0_0_0_00;
    localparam logic [8:0] C_NONE = 9'b0;
    // {PCWrite, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush}
    localparam logic [4:0] S_RUN   = 5'b11000;
    localparam logic [4:0] S_STALL = 5'b00000;
    localparam logic [4:0] S_BR    = 5'b11111;
    localparam logic [4:0] S_FL    = 5'b11100;

    typedef struct {
        string      tag;
        logic [8:0] ctrl;
        logic [5:0] op;
        logic [4:0] steer;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [8:0] obs_ctrl();
        return {ifc.RegDst_Out, ifc.ALUSrc_Out, ifc.MemtoReg_Out, ifc.RegWrite_Out,
                ifc.MemRead_Out, ifc.MemWrite_Out, ifc.Branch_Out, ifc.ALUOp_Out};
    endfunction

    function automatic logic [4:0] obs_steer();
        return {ifc.PCWrite_Out, ifc.IFID_Write_Out, ifc.IFID_Flush_Out,
                ifc.IDEX_Flush_Out, ifc.EXMEM_Flush_Out};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic [4:0] irt, input logic br);
        ifc.opcode_In       = op;
        ifc.rs_In           = rs;
        ifc.rt_In           = rt;
        ifc.idex_MemRead_In = mr;
        ifc.idex_rt_In      = irt;
        ifc.branch_taken_In = br;
    endtask

    task automatic pop_cmp();
        exp_t e;
        logic [8:0] oc;
        logic [4:0] os;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 8'd1, 8'd0);
            return;
        end
        e  = sb.pop_front();
        oc = obs_ctrl();
        os = obs_steer();
        n_assert++;
        assert (oc === e.ctrl) else begin
            n_fail++;
            $error("FAIL %s.ctrl observed=%b expected=%b", e.tag, oc, e.ctrl);
        end
        n_assert++;
        assert (ifc.opcode_Out === e.op) else begin
            n_fail++;
            $error("FAIL %s.opcode observed=%b expected=%b", e.tag, ifc.opcode_Out, e.op);
        end
        n_assert++;
        assert (os === e.steer) else begin
            n_fail++;
            $error("FAIL %s.steer observed=%b expected=%b", e.tag, os, e.steer);
        end
    endtask

    task automatic expect_now(input string tag, input logic [8:0] c, input logic [5:0] op,
                              input logic [4:0] s);
        exp_t e;
        e.tag = tag; e.ctrl = c; e.op = op; e.steer = s;
        sb.push_back(e);
        pop_cmp();
    endtask

    task automatic cyc(input string tag, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic mr, input logic [4:0] irt, input logic br,
                       input logic [8:0] c, input logic [5:0] eop, input logic [4:0] s);
        exp_t e;
        @(posedge clk);
        #1;
        drive(op, rs, rt, mr, irt, br);
        e.tag = tag; e.ctrl = c; e.op = eop; e.steer = s;
        sb.push_back(e);
        @(negedge clk);
        pop_cmp();
    endtask

    initial begin
        rst = 1'b0;
        drive(6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        #3;
        chk("rst_stall_cnt", ifc.stall_count_Out, 8'd0);
        chk("rst_flush_cnt", ifc.flush_count_Out, 8'd0);
        chk("rst_illegal", {7'd0, ifc.illegal_Out}, 8'd0);
        expect_now("rst_decode", C_R, 6'h00, S_RUN);
        @(negedge clk);
        rst = 1'b1;

        cyc("dec_r",    6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_R,    6'h00, S_RUN);
        cyc("dec_lw",   6'h23, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_LW,   6'h23, S_RUN);
        cyc("dec_sw",   6'h2B, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_SW,   6'h2B, S_RUN);
        cyc("dec_beq",  6'h04, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_BEQ,  6'h04, S_RUN);
        cyc("dec_addi", 6'h08, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_ADDI, 6'h08, S_RUN);

        cyc("ldu_stall", 6'h00, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, C_NONE, 6'h00, S_STALL);
        cyc("ldu_after", 6'h00, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, C_R,    6'h00, S_RUN);
        chk("ldu_stall_cnt", ifc.stall_count_Out, 8'd1);

        cyc("rt_zero",  6'h00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, C_R,    6'h00, S_RUN);
        cyc("addi_rt",  6'h08, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, C_ADDI, 6'h08, S_RUN);
        cyc("lw_rt",    6'h23, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, C_LW,   6'h23, S_RUN);
        cyc("sw_rt",    6'h2B, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, C_NONE, 6'h00, S_STALL);
        cyc("sw_after", 6'h2B, 5'd1, 5'd9, 1'b1, 5'd9, 1'b0, C_SW,   6'h2B, S_RUN);
        chk("sw_stall_cnt", ifc.stall_count_Out, 8'd2);

        cyc("br",     6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, C_NONE, 6'h00, S_BR);
        cyc("br_fl",  6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_NONE, 6'h00, S_FL);
        cyc("br_run", 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_R,    6'h00, S_RUN);
        chk("br_flush_cnt", ifc.flush_count_Out, 8'd1);

        cyc("haz_br",    6'h00, 5'd3, 5'd8, 1'b1, 5'd8, 1'b1, C_NONE, 6'h00, S_BR);
        cyc("haz_br_fl", 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_NONE, 6'h00, S_FL);
        chk("haz_br_stall_cnt", ifc.stall_count_Out, 8'd2);
        chk("haz_br_flush_cnt", ifc.flush_count_Out, 8'd2);
        cyc("haz_br_run", 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_R, 6'h00, S_RUN);

        chk("ill_pre", {7'd0, ifc.illegal_Out}, 8'd0);
        cyc("ill_op", 6'h3F, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_NONE, 6'h3F, S_RUN);
        chk("ill_same_cycle", {7'd0, ifc.illegal_Out}, 8'd0);
        cyc("ill_next", 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_R, 6'h00, S_RUN);
        chk("ill_set", {7'd0, ifc.illegal_Out}, 8'd1);

        for (int i = 0; i < 300; i++)
            cyc("br_sat", 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, C_NONE, 6'h00, S_BR);
        cyc("sat_fl", 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_NONE, 6'h00, S_FL);
        chk("flush_sat", ifc.flush_count_Out, 8'd255);
        cyc("sat_run", 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_R, 6'h00, S_RUN);
        chk("ill_held", {7'd0, ifc.illegal_Out}, 8'd1);

        cyc("pre_stall", 6'h00, 5'd3, 5'd8, 1'b1, 5'd8, 1'b0, C_NONE, 6'h00, S_STALL);
        @(posedge clk);
        #1;
        chk("in_stall_cnt", ifc.stall_count_Out, 8'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_stall_cnt", ifc.stall_count_Out, 8'd0);
        chk("async_flush_cnt", ifc.flush_count_Out, 8'd0);
        chk("async_illegal", {7'd0, ifc.illegal_Out}, 8'd0);
        expect_now("async_state_run", C_NONE, 6'h00, S_STALL);
        drive(6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        cyc("post_rst_a", 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_R, 6'h00, S_RUN);
        cyc("post_rst_b", 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_R, 6'h00, S_RUN);
        chk("post_rst_stall_cnt", ifc.stall_count_Out, 8'd0);

        cyc("pre_fl", 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, C_NONE, 6'h00, S_BR);
        @(posedge clk);
        #1;
        drive(6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        expect_now("async_fl_abort", C_R, 6'h00, S_RUN);
        chk("async_fl_cnt", ifc.flush_count_Out, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc("post_fl_rst", 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, C_R, 6'h00, S_RUN);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
